// File: rtl/add_serial.sv
// Bit-serial adder: one full-adder cell and a 1-bit carry register, LSB first, WIDTH+1 cycles per operation.
// Build option ADD_SERIAL_OVF_EN adds a registered signed-overflow output.
module add_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef ADD_SERIAL_OVF_EN
    ,
    output logic             overflow
`endif
);

    // state | meaning
    // IDLE  | waiting for start, operands not yet latched
    // RUN   | one operand bit consumed per cycle, WIDTH cycles
    // DONE  | result valid, done pulses; start here re-enters RUN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic             accept;

    assign fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                ready = 1'b0;
                busy  = 1'b1;
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sum bits shift into the top of a_sr as augend bits leave the bottom,
    // so after WIDTH steps a_sr holds the finished sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
`ifdef ADD_SERIAL_OVF_EN
            overflow  <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= carry_in;
            count <= '0;
        end else if (state == RUN) begin
            a_sr  <= {fa_sum, a_sr[WIDTH-1:1]};
            b_sr  <= b_sr >> 1;
            carry <= fa_carry;
            count <= count + CW'(1);
            if (last_bit) begin
                sum       <= {fa_sum, a_sr[WIDTH-1:1]};
                carry_out <= fa_carry;
`ifdef ADD_SERIAL_OVF_EN
                overflow  <= carry ^ fa_carry;
`endif
            end
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// Directed self-checking bench for add_serial (WIDTH=4), including an exhaustive operand sweep.
module tb_add_serial;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef ADD_SERIAL_OVF_EN
    logic         overflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int pulses  = 0;
    logic [W-1:0] prev_sum = '0;

    add_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
`ifdef ADD_SERIAL_OVF_EN
        ,
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply start for one cycle, then scramble the inputs to show they are not re-read.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a        = av;
        b        = bv;
        carry_in = cv;
        start    = 1'b1;
        step();
        start    = 1'b0;
        a        = ~av;
        b        = ~bv;
        carry_in = ~cv;
        lat      = 1;
    endtask

    task automatic wait_done(input string tag, input logic [W-1:0] es, input logic ec, input logic eo);
        while (!done && lat < 20) begin
            if (lat == 2) begin
                check({tag, " busy_run"}, 32'(busy), 32'd1);
                check({tag, " ready_run"}, 32'(ready), 32'd0);
                check({tag, " sum_held"}, 32'(sum), 32'(prev_sum));
            end
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(W + 1));
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " carry_out"}, 32'(carry_out), 32'(ec));
`ifdef ADD_SERIAL_OVF_EN
        check({tag, " overflow"}, 32'(overflow), 32'(eo));
`else
        if (eo === 1'bx) check({tag, " ovf_unused"}, 32'd0, 32'd1);
`endif
        prev_sum = es;
    endtask

    initial begin
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] es;
        logic         eo;
        int           t;

        // Reset state
        step();
        step();
        check("rst ready", 32'(ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst carry_out", 32'(carry_out), 32'd0);
`ifdef ADD_SERIAL_OVF_EN
        check("rst overflow", 32'(overflow), 32'd0);
`endif

        // First start on the first edge with rst low: 3+5 = 8, signed overflow
        rst = 1'b0;
        launch(4'd3, 4'd5, 1'b0);
        wait_done("op3p5", 4'd8, 1'b0, 1'b1);
        step();
        check("op3p5 done_one_cycle", 32'(done), 32'd0);
        check("op3p5 back_idle", 32'(ready), 32'd1);
        check("op3p5 sum_hold", 32'(sum), 32'd8);

        // 15+0+1 wraps to 0 with carry out, no signed overflow
        launch(4'd15, 4'd0, 1'b1);
        wait_done("op15c", 4'd0, 1'b1, 1'b0);
        step();

        // start during RUN is ignored
        launch(4'd6, 4'd2, 1'b0);
        a     = 4'd1;
        b     = 4'd1;
        start = 1'b1;
        step();
        lat++;
        start = 1'b0;
        wait_done("ignore", 4'd8, 1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) pulses++;
        end
        check("ignore extra_done", 32'(pulses), 32'd0);

        // Back-to-back: second start held in the DONE cycle
        launch(4'd3, 4'd5, 1'b0);
        wait_done("b2b first", 4'd8, 1'b0, 1'b1);
        launch(4'd9, 4'd9, 1'b1);
        check("b2b busy_after_accept", 32'(busy), 32'd1);
        wait_done("b2b second", 4'd3, 1'b1, 1'b1);
        step();

        // Reset in RUN cycle 2 aborts with no done pulse
        launch(4'd7, 4'd7, 1'b0);
        step();
        rst = 1'b1;
        step();
        check("abort ready", 32'(ready), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort carry_out", 32'(carry_out), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_over_start busy", 32'(busy), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) pulses++;
        end
        check("abort no_done", 32'(pulses), 32'd0);
        prev_sum = '0;
        launch(4'd2, 4'd2, 1'b0);
        wait_done("after_abort", 4'd4, 1'b0, 1'b0);
        step();

        // Exhaustive sweep against a+b+carry_in
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    ea = 4'(ai);
                    eb = 4'(bi);
                    t  = ai + bi + ci;
                    es = 4'(t);
                    eo = (ea[W-1] == eb[W-1]) && (es[W-1] != ea[W-1]);
                    launch(ea, eb, 1'(ci));
                    wait_done("sweep", es, t >= 16, eo);
                    step();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
